// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: RAW hazard detection for the decode stage,
// taken-branch flush of IF/ID, full-pipeline freeze while a data-memory access
// is outstanding (with timeout), and saturating stall/flush statistics.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow; hazards stall ID, taken branches flush IF/ID
// MEM_WAIT | data-memory access outstanding; whole pipeline frozen
// ERR      | memory never answered; pipeline frozen until reset
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             forward_en_i,
  input  logic [4:0]       src1_i,
  input  logic [4:0]       src2_i,
  input  logic             is_imm_i,
  input  logic             st_or_bne_i,
  input  logic [1:0]       branch_comm_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [4:0]       mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             mem_access_i,
  input  logic             mem_ready_i,
  output logic             hazard_detected_o,
  output logic             freeze_pc_o,
  output logic             freeze_if_id_o,
  output logic             flush_if_id_o,
  output logic             freeze_all_o,
  output logic             mem_timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic use1, use2;
  logic exe_match, mem_match;
  logic exe_wb_hit, load_hit, mem_wb_hit;
  logic is_branch;
  logic raw;

  logic haz, fpc, fif, fl, fa;

  // RAW detection on the operands ID is about to read; register 0 never hazards
  always_comb begin
    use1       = (src1_i != 5'd0);
    use2       = (!is_imm_i || st_or_bne_i) && (src2_i != 5'd0);
    exe_match  = (use1 && (src1_i == exe_dest_i)) || (use2 && (src2_i == exe_dest_i));
    mem_match  = (use1 && (src1_i == mem_dest_i)) || (use2 && (src2_i == mem_dest_i));
    exe_wb_hit = exe_match && exe_wb_en_i;
    load_hit   = exe_wb_hit && exe_mem_r_en_i;
    mem_wb_hit = mem_match && mem_wb_en_i;
    is_branch  = (branch_comm_i != 2'd0);
    // Branches compare in ID, so forwarding into EXE cannot help them.
    if (forward_en_i) begin
      raw = load_hit || (is_branch && (exe_wb_hit || mem_wb_hit));
    end else begin
      raw = exe_wb_hit || mem_wb_hit;
    end
  end

  // Next-state and output decode; memory freeze beats hazard beats flush
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    haz     = 1'b0;
    fpc     = 1'b0;
    fif     = 1'b0;
    fl      = 1'b0;
    fa      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_access_i && !mem_ready_i) begin
          fa      = 1'b1;
          fpc     = 1'b1;
          fif     = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (raw) begin
          haz = 1'b1;
          fpc = 1'b1;
          fif = 1'b1;
        end else begin
          fl = branch_taken_i;
        end
      end
      MEM_WAIT: begin
        fa  = 1'b1;
        fpc = 1'b1;
        fif = 1'b1;
        if (mem_ready_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      ERR: begin
        fa    = 1'b1;
        fpc   = 1'b1;
        fif   = 1'b1;
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    // Outputs must read zero for the whole time reset is held.
    if (reset_i) begin
      haz = 1'b0;
      fpc = 1'b0;
      fif = 1'b0;
      fl  = 1'b0;
      fa  = 1'b0;
    end
  end

  // Saturating statistics: stall cycles and taken-branch flushes
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (fpc && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (fl && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // State, wait counter, sticky error and statistics registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hazard_detected_o = haz;
  assign freeze_pc_o       = fpc;
  assign freeze_if_id_o    = fif;
  assign flush_if_id_o     = fl;
  assign freeze_all_o      = fa;
  assign mem_timeout_err_o = err_q;
  assign stall_cnt_o       = stall_q;
  assign flush_cnt_o       = flush_q;

endmodule
